// File: rtl/lsu_bus_if.sv
// Load/store unit: turns core load/store requests into req/ack bus cycles,
// lane-formats store data and load results, and stalls the PC while a cycle is open.
module lsu_bus_if #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Fault,
  output logic        BusErr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  dbg_state
);

  // Bus handshake: bus_req rises the cycle after a legal request and stays high
  // with stable addr/we/be/wdata until the first cycle bus_ack=1 is seen while
  // busy (that cycle completes the transfer); bus_ack at any other time is ignored.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [31:0]     rd_q;

  logic        access;
  logic        idle_access;
  logic        illegal;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] d);
    logic [31:0] sh;
    sh = d >> {off, 3'b000};
    case (f3)
      3'b000:  fmt_load = {{24{sh[7]}}, sh[7:0]};
      3'b001:  fmt_load = {{16{sh[15]}}, sh[15:0]};
      3'b100:  fmt_load = {24'b0, sh[7:0]};
      3'b101:  fmt_load = {16'b0, sh[15:0]};
      default: fmt_load = sh;
    endcase
  endfunction

  assign access      = MemRead | MemWrite;
  assign idle_access = (state == S_IDLE) && access;

  always_comb begin
    illegal = 1'b0;
    if (MemRead && MemWrite) illegal = 1'b1;
    case (Funct3)
      3'b011, 3'b110, 3'b111: illegal = 1'b1;
      default: ;
    endcase
    if (MemWrite && Funct3[2]) illegal = 1'b1;
    if ((Funct3[1:0] == 2'b01) && Addr[0]) illegal = 1'b1;
    if ((Funct3[1:0] == 2'b10) && (Addr[1:0] != 2'b00)) illegal = 1'b1;
  end

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = WriteData;
    case (Funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << Addr[1:0];
        wdata_c = {4{WriteData[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << {Addr[1], 1'b0};
        wdata_c = {2{WriteData[15:0]}};
      end
      default: ;
    endcase
  end

  assign Fault     = reset_n && idle_access && illegal;
  assign Stall     = reset_n && ((idle_access && !illegal) || (state == S_BUSY));
  assign ReadData  = Fault ? 32'd0 : rd_q;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      to_cnt    <= '0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      rd_q      <= 32'd0;
      BusErr    <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
      bus_be    <= 4'b0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (idle_access && illegal) begin
            rd_q <= 32'd0;
          end else if (idle_access) begin
            f3_q      <= Funct3;
            off_q     <= Addr[1:0];
            bus_we    <= MemWrite;
            bus_addr  <= {Addr[31:2], 2'b00};
            bus_be    <= be_c;
            bus_wdata <= wdata_c;
            bus_req   <= 1'b1;
            to_cnt    <= '0;
            state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            // Store cycles leave the last load result visible.
            if (!bus_we) rd_q <= fmt_load(f3_q, off_q, bus_rdata);
            state   <= S_DONE;
          end else if (to_cnt == TO_LAST) begin
            bus_req <= 1'b0;
            rd_q    <= 32'd0;
            BusErr  <= 1'b1;
            state   <= S_DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_DONE: begin
          BusErr <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_if.sv
// Bench for lsu_bus_if: directed scenarios followed by randomized accesses,
// checked against a size/offset reference model of the load/store rules.
module tb_lsu_bus_if;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr, WriteData;
  logic [31:0] ReadData;
  logic        Stall, Fault, BusErr;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd = 32'd0;

  lsu_bus_if #(.TIMEOUT(255), .TO_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData),
    .Stall(Stall), .Fault(Fault), .BusErr(BusErr), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic int m_size(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit m_legal(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (rd && wr) return 0;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 0;
    if (wr && f3 >= 3'd4) return 0;
    if (off % m_size(f3) != 0) return 0;
    return 1;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = m_size(f3);
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (m_size(f3))
      1:       return (wd % 256) * 32'h01010101;
      2:       return (wd % 65536) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] d);
    longint v;
    v = longint'(d / (32'd1 << (8 * (a % 4))));
    case (f3)
      3'd0: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
      3'd1: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
      3'd4: v = v % 256;
      3'd5: v = v % 65536;
      default: ;
    endcase
    return 32'(v);
  endfunction

  // driver: called just after a falling edge, returns just after a falling edge
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int ack_dly, input logic [31:0] rdata);
    int stalls;
    stalls = 0;
    MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; WriteData = wd;
    #1;
    if (!m_legal(rd, wr, f3, a)) begin
      chk("fault_flag", {31'd0, Fault}, 32'd1);
      chk("fault_stall", {31'd0, Stall}, 32'd0);
      chk("fault_rdata", ReadData, 32'd0);
      @(posedge clk); #1;
      chk("fault_no_req", {31'd0, bus_req}, 32'd0);
      MemRead = 1'b0; MemWrite = 1'b0;
      #1;
      chk("fault_clear", {31'd0, Fault}, 32'd0);
      last_rd = 32'd0;
      @(negedge clk);
      return;
    end
    chk("legal_no_fault", {31'd0, Fault}, 32'd0);
    if (Stall) stalls++;
    @(posedge clk); #1;
    chk("req_high", {31'd0, bus_req}, 32'd1);
    chk("bus_addr", bus_addr, {a[31:2], 2'b00});
    chk("bus_we", {31'd0, bus_we}, {31'd0, wr});
    chk("bus_be", {28'd0, bus_be}, {28'd0, m_be(f3, a)});
    if (wr) chk("bus_wdata", bus_wdata, m_wdata(f3, wd));
    Addr = $urandom; Funct3 = 3'($urandom); WriteData = $urandom;
    @(negedge clk);
    for (int i = 0; i < ack_dly; i++) begin
      #1;
      if (Stall) stalls++;
      chk("req_wait", {31'd0, bus_req}, 32'd1);
      @(negedge clk);
    end
    bus_ack = 1'b1; bus_rdata = rdata;
    #1;
    if (Stall) stalls++;
    if (!rd) exp_q.push_back(last_rd);
    else exp_q.push_back(m_load(f3, a, rdata));
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_rdata = $urandom;
    chk("done_stall", {31'd0, Stall}, 32'd0);
    chk("done_req", {31'd0, bus_req}, 32'd0);
    chk("done_buserr", {31'd0, BusErr}, 32'd0);
    last_rd = exp_q.pop_front();
    if (rd) chk("done_rdata", ReadData, last_rd);
    chk("stall_cycles", stalls, ack_dly + 2);
    MemRead = 1'b0; MemWrite = 1'b0;
    @(posedge clk); #1;
    chk("idle_hold_rdata", ReadData, last_rd);
    chk("idle_stall", {31'd0, Stall}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    int kind;
    reset_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'd0;
    Addr = 32'd0; WriteData = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
    @(negedge clk); @(negedge clk);
    MemRead = 1'b1; #1;
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    chk("rst_fault", {31'd0, Fault}, 32'd0);
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_rdata", ReadData, 32'd0);
    chk("rst_buserr", {31'd0, BusErr}, 32'd0);
    MemRead = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: SW with two wait cycles
    do_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 2, 32'h0);
    chk("t1_be", {28'd0, bus_be}, 32'hF);
    chk("t1_addr", bus_addr, 32'h100);
    chk("t1_wdata", bus_wdata, 32'hDEADBEEF);

    // 2: LB / LBU at 0x103
    do_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80112233);
    chk("t2_lb", ReadData, 32'hFFFFFF80);
    do_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80112233);
    chk("t2_lbu", ReadData, 32'h00000080);

    // 3: SH / LHU at 0x102
    do_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000ABCD, 0, 32'h0);
    chk("t3_be", {28'd0, bus_be}, 32'hC);
    chk("t3_wdata", bus_wdata, 32'hABCDABCD);
    do_access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 0, 32'hABCD0000);
    chk("t3_lhu", ReadData, 32'h0000ABCD);

    // 4: misaligned LW and read+write together
    do_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 32'h0);
    do_access(1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 0, 32'h0);

    // 5: timeout
    do_access(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 0, 32'h12345678);
    MemRead = 1'b1; Funct3 = 3'b010; Addr = 32'h300;
    @(posedge clk); #1;
    cnt = 0;
    while (bus_req && cnt < 400) begin
      cnt++;
      @(posedge clk); #1;
    end
    chk("to_req_cycles", cnt, 255);
    chk("to_buserr", {31'd0, BusErr}, 32'd1);
    chk("to_rdata", ReadData, 32'd0);
    chk("to_stall", {31'd0, Stall}, 32'd0);
    MemRead = 1'b0;
    @(posedge clk); #1;
    chk("to_buserr_clr", {31'd0, BusErr}, 32'd0);
    last_rd = 32'd0;
    @(negedge clk);

    // 6: reset during BUSY, then a stray ack
    do_access(1'b1, 1'b0, 3'b010, 32'h108, 32'h0, 0, 32'hCAFEF00D);
    MemRead = 1'b1; Funct3 = 3'b010; Addr = 32'h200;
    @(posedge clk); #1;
    chk("t6_req", {31'd0, bus_req}, 32'd1);
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("t6_req_async", {31'd0, bus_req}, 32'd0);
    chk("t6_stall", {31'd0, Stall}, 32'd0);
    MemRead = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h55555555;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("t6_ack_ignored_req", {31'd0, bus_req}, 32'd0);
    chk("t6_ack_ignored_rd", ReadData, 32'd0);
    chk("t6_idle_stall", {31'd0, Stall}, 32'd0);
    last_rd = 32'd0;
    @(negedge clk);

    // random accesses
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 9);
      do_access(kind >= 5, (kind >= 1 && kind <= 4) || kind == 0,
                3'($urandom_range(0, 7)), $urandom, $urandom,
                $urandom_range(0, 4), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
